// File: rtl/speck_round_step.sv
`default_nettype none
// ============================================================================
// Module      : speck_round_step
// Description : One SPECK128/128 iteration. Performs a single round of the
//               SPECK round function on a 2*WORD-bit block together with one
//               key-schedule expansion step, behind a start/finished
//               handshake. A controller either chains several instances or
//               reuses one instance, feeding data_out/key_out back into
//               data_in/key_in with round_ctr = 0, 1, 2, ...
//
//               Round : x' = (ROR(x,ALPHA) + y) ^ k ; y' = ROL(y,BETA) ^ x'
//               Key   : l' = (ROR(l,ALPHA) + k) ^ i ; k' = ROL(k,BETA) ^ l'
//               Both paths use the same latched (pre-update) k.
//
// Ports       : clk            rising-edge clock
//               rst_n          asynchronous active-low reset
//               signal_start   one-cycle start pulse, samples all operands
//               data_in        block {x,y}
//               key_in         key state {k,l}, k is the round key
//               round_ctr      round index XORed in by the key step
//               data_out       {x',y'} round result
//               key_out        {k',l'} next key state
//               finished       results valid (sticky until next start)
//               state_response debug view of the FSM state
//
// Revision    : 1.0 - initial release
// ============================================================================
module speck_round_step #(
    parameter int WORD  = 64,
    parameter int ALPHA = 8,
    parameter int BETA  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                signal_start,
    input  logic [2*WORD-1:0]   data_in,
    input  logic [2*WORD-1:0]   key_in,
    input  logic [WORD-1:0]     round_ctr,
    output logic [2*WORD-1:0]   data_out,
    output logic [2*WORD-1:0]   key_out,
    output logic                finished,
    output logic [3:0]          state_response
);

    // ------------------------------------------------------------------------
    // State encoding (exposed on state_response)
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_IDLE = 4'd0;
    localparam logic [3:0] c_LOAD = 4'd1;
    localparam logic [3:0] c_ADD  = 4'd2;
    localparam logic [3:0] c_XOR  = 4'd3;
    localparam logic [3:0] c_DONE = 4'd4;

    // ------------------------------------------------------------------------
    // Rotation helpers (fixed amounts, pure wiring)
    // ------------------------------------------------------------------------
    function automatic logic [WORD-1:0] f_ror(input logic [WORD-1:0] v);
        return (v >> ALPHA) | (v << (WORD - ALPHA));
    endfunction

    function automatic logic [WORD-1:0] f_rol(input logic [WORD-1:0] v);
        return (v << BETA) | (v >> (WORD - BETA));
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [3:0]        r_state;
    // Operands latched at the accepting start edge
    logic [WORD-1:0]   r_x;
    logic [WORD-1:0]   r_y;
    logic [WORD-1:0]   r_k;
    logic [WORD-1:0]   r_l;
    logic [WORD-1:0]   r_ctr;
    // Rotation stage
    logic [WORD-1:0]   r_ror_x;
    logic [WORD-1:0]   r_rol_y;
    logic [WORD-1:0]   r_ror_l;
    logic [WORD-1:0]   r_rol_k;
    // Addition stage
    logic [WORD-1:0]   r_sum_x;
    logic [WORD-1:0]   r_sum_l;
    // Results
    logic [2*WORD-1:0] r_data_out;
    logic [2*WORD-1:0] r_key_out;
    logic              r_finished;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [3:0]        w_state_d;
    logic [WORD-1:0]   w_x_d;
    logic [WORD-1:0]   w_y_d;
    logic [WORD-1:0]   w_k_d;
    logic [WORD-1:0]   w_l_d;
    logic [WORD-1:0]   w_ctr_d;
    logic [WORD-1:0]   w_ror_x_d;
    logic [WORD-1:0]   w_rol_y_d;
    logic [WORD-1:0]   w_ror_l_d;
    logic [WORD-1:0]   w_rol_k_d;
    logic [WORD-1:0]   w_sum_x_d;
    logic [WORD-1:0]   w_sum_l_d;
    logic [2*WORD-1:0] w_data_out_d;
    logic [2*WORD-1:0] w_key_out_d;
    logic              w_finished_d;

    // Final XOR stage. x' must be formed before y', and l' before k',
    // because the second word of each pair folds in the first.
    logic [WORD-1:0]   w_x_new;
    logic [WORD-1:0]   w_y_new;
    logic [WORD-1:0]   w_l_new;
    logic [WORD-1:0]   w_k_new;

    assign w_x_new = r_sum_x ^ r_k;
    assign w_y_new = r_rol_y ^ w_x_new;
    assign w_l_new = r_sum_l ^ r_ctr;
    assign w_k_new = r_rol_k ^ w_l_new;

    // ------------------------------------------------------------------------
    // Datapath and FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d    = r_state;
        w_x_d        = r_x;
        w_y_d        = r_y;
        w_k_d        = r_k;
        w_l_d        = r_l;
        w_ctr_d      = r_ctr;
        w_ror_x_d    = r_ror_x;
        w_rol_y_d    = r_rol_y;
        w_ror_l_d    = r_ror_l;
        w_rol_k_d    = r_rol_k;
        w_sum_x_d    = r_sum_x;
        w_sum_l_d    = r_sum_l;
        w_data_out_d = r_data_out;
        w_key_out_d  = r_key_out;
        w_finished_d = r_finished;

        case (r_state)
            // IDLE and DONE accept a start identically; DONE additionally
            // keeps presenting the previous result until the new one lands.
            c_IDLE, c_DONE: begin
                if (signal_start) begin
                    w_x_d        = data_in[2*WORD-1:WORD];
                    w_y_d        = data_in[WORD-1:0];
                    w_k_d        = key_in[2*WORD-1:WORD];
                    w_l_d        = key_in[WORD-1:0];
                    w_ctr_d      = round_ctr;
                    w_finished_d = 1'b0;
                    w_state_d    = c_LOAD;
                end
            end

            c_LOAD: begin
                w_ror_x_d = f_ror(r_x);
                w_rol_y_d = f_rol(r_y);
                w_ror_l_d = f_ror(r_l);
                w_rol_k_d = f_rol(r_k);
                w_state_d = c_ADD;
            end

            // Sums wrap modulo 2^WORD; the carry out is simply dropped.
            c_ADD: begin
                w_sum_x_d = r_ror_x + r_y;
                w_sum_l_d = r_ror_l + r_k;
                w_state_d = c_XOR;
            end

            c_XOR: begin
                w_data_out_d = {w_x_new, w_y_new};
                w_key_out_d  = {w_k_new, w_l_new};
                w_finished_d = 1'b1;
                w_state_d    = c_DONE;
            end

            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_k        <= '0;
            r_l        <= '0;
            r_ctr      <= '0;
            r_ror_x    <= '0;
            r_rol_y    <= '0;
            r_ror_l    <= '0;
            r_rol_k    <= '0;
            r_sum_x    <= '0;
            r_sum_l    <= '0;
            r_data_out <= '0;
            r_key_out  <= '0;
            r_finished <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_x        <= w_x_d;
            r_y        <= w_y_d;
            r_k        <= w_k_d;
            r_l        <= w_l_d;
            r_ctr      <= w_ctr_d;
            r_ror_x    <= w_ror_x_d;
            r_rol_y    <= w_rol_y_d;
            r_ror_l    <= w_ror_l_d;
            r_rol_k    <= w_rol_k_d;
            r_sum_x    <= w_sum_x_d;
            r_sum_l    <= w_sum_l_d;
            r_data_out <= w_data_out_d;
            r_key_out  <= w_key_out_d;
            r_finished <= w_finished_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------------
    assign data_out       = r_data_out;
    assign key_out        = r_key_out;
    assign finished       = r_finished;
    assign state_response = r_state;

endmodule
`default_nettype wire

// File: tb/tb_speck_round_step.sv
`default_nettype none
// ============================================================================
// Module      : tb_speck_round_step
// Description : Directed self-checking bench for speck_round_step. Drives a
//               linear sequence of hand-computed vectors, including the
//               SPECK128/128 reference encryption chained over 32 rounds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speck_round_step;

    logic         clk;
    logic         rst_n;
    logic         signal_start;
    logic [127:0] data_in;
    logic [127:0] key_in;
    logic [63:0]  round_ctr;
    logic [127:0] data_out;
    logic [127:0] key_out;
    logic         finished;
    logic [3:0]   state_response;

    int checks;
    int failures;

    speck_round_step #(
        .WORD  (64),
        .ALPHA (8),
        .BETA  (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .signal_start   (signal_start),
        .data_in        (data_in),
        .key_in         (key_in),
        .round_ctr      (round_ctr),
        .data_out       (data_out),
        .key_out        (key_out),
        .finished       (finished),
        .state_response (state_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high across exactly one edge (the accept edge).
    task automatic start_op(input logic [127:0] d, input logic [127:0] k, input logic [63:0] c);
        data_in      = d;
        key_in       = k;
        round_ctr    = c;
        signal_start = 1'b1;
        tick();
        signal_start = 1'b0;
    endtask

    initial begin
        logic [127:0] d_fb;
        logic [127:0] k_fb;

        checks       = 0;
        failures     = 0;
        signal_start = 1'b0;
        data_in      = '0;
        key_in       = '0;
        round_ctr    = '0;
        rst_n        = 1'b1;
        #1;
        rst_n        = 1'b0;
        #1;

        // ---- Reset state ----
        check("rst_state",    128'(state_response), 128'd0);
        check("rst_finished", 128'(finished),       128'd0);
        check("rst_data",     data_out,             128'd0);
        check("rst_key",      key_out,              128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---- Basic round, with per-stage state walk ----
        start_op({64'h100, 64'h0}, 128'd0, 64'd0);
        check("t2_state_load", 128'(state_response), 128'd1);
        check("t2_fin_load",   128'(finished),       128'd0);
        tick();
        check("t2_state_add",  128'(state_response), 128'd2);
        tick();
        check("t2_state_xor",  128'(state_response), 128'd3);
        check("t2_fin_xor",    128'(finished),       128'd0);
        tick();
        check("t2_state_done", 128'(state_response), 128'd4);
        check("t2_fin_done",   128'(finished),       128'd1);
        check("t2_data",       data_out, {64'h1, 64'h1});
        check("t2_key",        key_out,  128'd0);
        tick();
        check("t2_fin_sticky", 128'(finished),       128'd1);

        // ---- Carry wrap out of bit 63 ----
        start_op({64'hFFFF_FFFF_FFFF_FFFF, 64'h1}, 128'd0, 64'd0);
        tick(); tick(); tick();
        check("t3_data", data_out, {64'h0, 64'h8});

        // ---- Key step with nonzero round counter ----
        start_op(128'd0, {64'h0, 64'h100}, 64'd5);
        tick(); tick(); tick();
        check("t4_key",  key_out,  {64'h4, 64'h4});
        check("t4_data", data_out, 128'd0);

        // ---- Mixed vector: both paths use the same pre-update k ----
        start_op({64'h200, 64'h1}, {64'h10, 64'h0}, 64'd0);
        tick(); tick(); tick();
        check("mix_data", data_out, {64'h13, 64'h1B});
        check("mix_key",  key_out,  {64'h90, 64'h10});

        // ---- Handshake: input change after accept, start during ADD ----
        start_op({64'h100, 64'h0}, 128'd0, 64'd0);
        data_in = {64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        key_in  = {64'h0, 64'h100};
        round_ctr = 64'd5;
        tick();
        check("hs_state_add", 128'(state_response), 128'd2);
        signal_start = 1'b1;
        tick();
        signal_start = 1'b0;
        check("hs_ignored_state", 128'(state_response), 128'd3);
        tick();
        check("hs_state_done", 128'(state_response), 128'd4);
        check("hs_data",       data_out, {64'h1, 64'h1});
        check("hs_key",        key_out,  128'd0);

        // ---- Start in DONE: finished drops, result returns 4 edges later ----
        start_op({64'hFFFF_FFFF_FFFF_FFFF, 64'h1}, 128'd0, 64'd0);
        check("dn_fin_drop",  128'(finished), 128'd0);
        check("dn_data_held", data_out, {64'h1, 64'h1});
        tick(); tick();
        check("dn_fin_not_yet", 128'(finished), 128'd0);
        tick();
        check("dn_fin_back", 128'(finished), 128'd1);
        check("dn_data",     data_out, {64'h0, 64'h8});

        // ---- Start held high in DONE: back-to-back operations ----
        data_in      = 128'd0;
        key_in       = {64'h0, 64'h100};
        round_ctr    = 64'd5;
        signal_start = 1'b1;
        tick();
        check("b2b_accept1", 128'(state_response), 128'd1);
        tick(); tick(); tick();
        check("b2b_fin1", 128'(finished), 128'd1);
        check("b2b_key1", key_out, {64'h4, 64'h4});
        data_in   = {64'h200, 64'h1};
        key_in    = {64'h10, 64'h0};
        round_ctr = 64'd0;
        tick();
        check("b2b_accept2", 128'(state_response), 128'd1);
        check("b2b_fin_drop", 128'(finished), 128'd0);
        tick(); tick(); tick();
        signal_start = 1'b0;
        check("b2b_data2", data_out, {64'h13, 64'h1B});
        check("b2b_key2",  key_out,  {64'h90, 64'h10});

        // ---- Asynchronous reset in the middle of ADD ----
        tick();
        start_op({64'h100, 64'h0}, 128'd0, 64'd0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_state", 128'(state_response), 128'd0);
        check("ar_fin",   128'(finished),       128'd0);
        check("ar_data",  data_out,             128'd0);
        check("ar_key",   key_out,              128'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("ar_no_pulse_fin",   128'(finished),       128'd0);
        check("ar_no_pulse_state", 128'(state_response), 128'd0);

        // ---- Full SPECK128/128 encryption, 32 chained rounds ----
        d_fb = 128'h6C61766975716520_7469206564616D20;
        k_fb = 128'h0706050403020100_0F0E0D0C0B0A0908;
        for (int r = 0; r < 32; r++) begin
            start_op(d_fb, k_fb, 64'(r));
            tick(); tick(); tick();
            d_fb = data_out;
            k_fb = key_out;
        end
        check("cipher_fin",  128'(finished), 128'd1);
        check("cipher_data", d_fb, 128'hA65D985179783265_7860FEDF5C570D18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
